// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// Module  : fetch_controller
// Brief   : PC sequencer that feeds a 2-entry {pc, instr} buffer, with
//           redirect flush. Define FETCH_MISALIGN_TRAP_EN to trap misaligned
//           redirects into a sticky FAULT state.
// Revision: 1.0
// ============================================================================
module fetch_controller #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_en,
   output logic [31:0] instr_raddr,
   input  logic [31:0] instr_code,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        misalign_fault
);

   localparam logic [31:0] c_align_mask = 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_TRAP_EN
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FAULT = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1
   } state_t;
`endif

   logic [31:0] r_pc;
   logic [31:0] r_fifo_pc    [2];
   logic [31:0] r_fifo_instr [2];
   logic        r_head;
   logic [1:0]  r_count;

   state_t      w_state;
   logic        w_redirect;
   logic        w_misalign;
   logic        w_push;
   logic        w_pop;
   logic        w_tail;

`ifdef FETCH_MISALIGN_TRAP_EN
   state_t      r_state;

   // RUN/IDLE track fetch_en within the same cycle; FAULT is held until reset.
   always_comb begin
      w_state    = (r_state == S_FAULT) ? S_FAULT : (fetch_en ? S_RUN : S_IDLE);
      w_redirect = redirect_valid && (r_state != S_FAULT);
      w_misalign = w_redirect && (redirect_pc[1:0] != 2'b00);
   end

   assign misalign_fault = (r_state == S_FAULT);
`else
   always_comb begin
      w_state    = fetch_en ? S_RUN : S_IDLE;
      w_redirect = redirect_valid;
      w_misalign = 1'b0;
   end

   assign misalign_fault = 1'b0;
`endif

   // Redirect wins over both push and pop; a pop frees a slot for a same-cycle push.
   assign w_pop  = (r_count != 2'd0) && out_ready && !w_redirect;
   assign w_push = (w_state == S_RUN) && !w_redirect && ((r_count != 2'd2) || w_pop);
   assign w_tail = r_head ^ r_count[0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc    <= RESET_PC;
         r_head  <= 1'b0;
         r_count <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            r_fifo_pc[i]    <= 32'd0;
            r_fifo_instr[i] <= 32'd0;
         end
`ifdef FETCH_MISALIGN_TRAP_EN
         r_state <= S_IDLE;
`endif
      end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
         r_state <= w_misalign ? S_FAULT : w_state;
`endif
         if (w_redirect) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
            if (!w_misalign) begin
               r_pc <= redirect_pc & c_align_mask;
            end
         end else begin
            if (w_push) begin
               r_fifo_pc[w_tail]    <= r_pc;
               r_fifo_instr[w_tail] <= instr_code;
               r_pc                 <= r_pc + 32'd4;
            end
            if (w_pop) begin
               r_head <= ~r_head;
            end
            if (w_push && !w_pop) begin
               r_count <= r_count + 2'd1;
            end else if (!w_push && w_pop) begin
               r_count <= r_count - 2'd1;
            end
         end
      end
   end

   assign instr_raddr = r_pc;
   assign out_valid   = (r_count != 2'd0);
   assign out_instr   = r_fifo_instr[r_head];
   assign out_pc      = r_fifo_pc[r_head];

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_controller
// Brief   : Directed testbench for fetch_controller; ROM word = addr ^ C0DE_0000.
// Revision: 1.0
// ============================================================================
module tb_fetch_controller;

   logic        clk;
   logic        reset;
   logic        fetch_en;
   logic [31:0] instr_raddr;
   logic [31:0] instr_code;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        misalign_fault;

   int tests;
   int failed;

   fetch_controller #(.RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .reset          (reset),
      .fetch_en       (fetch_en),
      .instr_raddr    (instr_raddr),
      .instr_code     (instr_code),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .misalign_fault (misalign_fault)
   );

   assign instr_code = instr_raddr ^ 32'hC0DE_0000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      tests          = 0;
      failed         = 0;
      reset          = 1'b1;
      fetch_en       = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      #1;
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_pc",    out_pc, 32'd0);
      check("rst_instr", out_instr, 32'd0);
      check("rst_raddr", instr_raddr, 32'd0);
      check("rst_fault", {31'd0, misalign_fault}, 32'd0);
      tick();

      // Streaming from reset release
      reset = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
      tick();
      check("s0_valid", {31'd0, out_valid}, 32'd1);
      check("s0_pc",    out_pc, 32'h0000_0000);
      check("s0_instr", out_instr, 32'hC0DE_0000);
      tick();
      check("s1_pc",    out_pc, 32'h0000_0004);
      check("s1_instr", out_instr, 32'hC0DE_0004);
      tick();
      check("s2_pc",    out_pc, 32'h0000_0008);
      check("s2_instr", out_instr, 32'hC0DE_0008);

      // Back-pressure: buffer saturates, pc stalls at 8
      reset = 1'b1;
      tick();
      reset = 1'b0; fetch_en = 1'b1; out_ready = 1'b0;
      repeat (5) tick();
      check("bp_raddr", instr_raddr, 32'h0000_0008);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_head",  out_pc, 32'h0000_0000);
      out_ready = 1'b1;
      tick();
      check("bp_pc4",    out_pc, 32'h0000_0004);
      check("bp_instr4", out_instr, 32'hC0DE_0004);
      tick();
      check("bp_pc8",    out_pc, 32'h0000_0008);

      // Redirect while full flushes stale entries
      out_ready = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
      tick();
      check("rd_valid", {31'd0, out_valid}, 32'd0);
      check("rd_raddr", instr_raddr, 32'h0000_0040);
      redirect_valid = 1'b0; out_ready = 1'b1;
      tick();
      check("rd_pc40",    out_pc, 32'h0000_0040);
      check("rd_instr40", out_instr, 32'hC0DE_0040);
      tick();
      check("rd_pc44", out_pc, 32'h0000_0044);

      // PC wrap at top of address space
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      tick();
      check("wr_pc",    out_pc, 32'hFFFF_FFFC);
      check("wr_instr", out_instr, 32'h3F21_FFFC);
      check("wr_raddr", instr_raddr, 32'h0000_0000);
      tick();
      check("wr_pc0", out_pc, 32'h0000_0000);
      check("wr_raddr4", instr_raddr, 32'h0000_0004);

      // IDLE holds pc and buffer contents
      fetch_en = 1'b0; out_ready = 1'b0;
      repeat (2) tick();
      check("id_raddr", instr_raddr, 32'h0000_0004);
      check("id_pc",    out_pc, 32'h0000_0000);
      check("id_valid", {31'd0, out_valid}, 32'd1);

      // Misaligned redirect
      fetch_en = 1'b1; out_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0042;
      tick();
`ifdef FETCH_MISALIGN_TRAP_EN
      check("ma_fault", {31'd0, misalign_fault}, 32'd1);
      check("ma_valid", {31'd0, out_valid}, 32'd0);
      check("ma_raddr", instr_raddr, 32'h0000_0004);
      redirect_pc = 32'h0000_0080;
      tick();
      redirect_valid = 1'b0;
      repeat (2) tick();
      check("ma_hold_valid", {31'd0, out_valid}, 32'd0);
      check("ma_hold_raddr", instr_raddr, 32'h0000_0004);
      check("ma_hold_fault", {31'd0, misalign_fault}, 32'd1);
`else
      check("ma_fault", {31'd0, misalign_fault}, 32'd0);
      check("ma_valid", {31'd0, out_valid}, 32'd0);
      check("ma_raddr", instr_raddr, 32'h0000_0040);
      redirect_valid = 1'b0;
      tick();
      check("ma_pc40", out_pc, 32'h0000_0040);
      check("ma_valid1", {31'd0, out_valid}, 32'd1);
`endif

      // Asynchronous reset mid-stream with a full buffer
      reset = 1'b1;
      tick();
      reset = 1'b0; fetch_en = 1'b1; out_ready = 1'b0;
      repeat (2) tick();
      check("ar_full_valid", {31'd0, out_valid}, 32'd1);
      check("ar_full_raddr", instr_raddr, 32'h0000_0008);
      #2;
      reset = 1'b1;
      #1;
      check("ar_valid", {31'd0, out_valid}, 32'd0);
      check("ar_pc",    out_pc, 32'd0);
      check("ar_instr", out_instr, 32'd0);
      check("ar_raddr", instr_raddr, 32'd0);
      check("ar_fault", {31'd0, misalign_fault}, 32'd0);
      tick();
      reset = 1'b0; out_ready = 1'b1;
      tick();
      check("ar_rel_valid", {31'd0, out_valid}, 32'd1);
      check("ar_rel_pc",    out_pc, 32'h0000_0000);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
